// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared state encoding and sizing constants for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int C_DEFAULT_WIDTH = 4;
    localparam int C_DEFAULT_CNT_W = $clog2(C_DEFAULT_WIDTH + 1);

    // Step counter must hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : divider_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_rem_wide;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign w_rem_wide = {i_rem, i_dvd_bit};
    assign w_ge       = (w_rem_wide >= {1'b0, i_divisor});
    // When w_ge holds the true difference is below the divisor, so the low bits suffice.
    assign w_diff     = w_rem_wide[WIDTH-1:0] - i_divisor;
    assign o_rem      = w_ge ? w_diff : w_rem_wide[WIDTH-1:0];
    assign o_q_bit    = w_ge;

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider, one quotient bit/clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int C_CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_rem_next;
    logic               w_q_bit;
    logic               w_accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    assign w_accept = start && (r_state != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + C_CNT_W'(1);
                    if (r_cnt == C_CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_DONE;
                        busy    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // r_dvd is never shifted on the zero-divisor path, so it still holds the dividend.
                    done        <= 1'b1;
                    quotient    <= r_dbz ? '1 : r_quo;
                    remainder   <= r_dbz ? r_dvd : r_rem;
                    div_by_zero <= r_dbz;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_accept) begin
                r_dvd <= dividend;
                r_dvs <= divisor;
                r_rem <= '0;
                r_quo <= '0;
                r_cnt <= '0;
                r_dbz <= (divisor == '0);
                if (divisor == '0) begin
                    r_state <= ST_DONE;
                    busy    <= 1'b0;
                end else begin
                    r_state <= ST_RUN;
                    busy    <= 1'b1;
                end
            end
        end
    end

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int C_W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [C_W-1:0] dividend;
    logic [C_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [C_W-1:0] quotient;
    logic [C_W-1:0] remainder;
    logic           div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.WIDTH(C_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Shift-add reference multiplier.
    function automatic int mul_model(input int a, input int b);
        int acc = 0;
        for (int i = 0; i < C_W; i++) begin
            if (b[i]) acc = acc + (a << i);
        end
        return acc;
    endfunction

    // Waits for done; lat counts edges after the accepting edge, bcnt counts busy samples.
    task automatic wait_done(output int lat, inout int bcnt);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            lat = k;
            if (done) break;
            if (busy) bcnt++;
        end
        if (!done) check_eq("done_timeout", done, 1);
    endtask

    task automatic run_div(input string tag, input int a, input int b, input int exp_q,
                           input int exp_r, input int exp_dbz, input int exp_lat);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1; dividend = C_W'(a); divisor = C_W'(b);
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        wait_done(lat, bcnt);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_q"}, quotient, exp_q);
        check_eq({tag, "_r"}, remainder, exp_r);
        check_eq({tag, "_dbz"}, div_by_zero, exp_dbz);
        check_eq({tag, "_busy_cycles"}, bcnt, (exp_dbz != 0) ? 0 : C_W);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_q_hold"}, quotient, exp_q);
    endtask

    initial begin
        int lat;
        int bcnt;
        int eq;
        int er;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_q", quotient, 0);
        check_eq("rst_r", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        @(negedge clk); rst = 1'b0;

        run_div("d13_3", 13, 3, 4, 1, 0, 5);
        run_div("d15_1", 15, 1, 15, 0, 0, 5);
        run_div("d2_7", 2, 7, 0, 2, 0, 5);
        run_div("d0_5", 0, 5, 0, 0, 0, 5);
        run_div("d9_0", 9, 0, 15, 9, 1, 1);
        run_div("d8_2", 8, 2, 4, 0, 0, 5);

        // Ignored start while busy, then back-to-back start in the DONE-state cycle.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0; dividend = 4'd15; divisor = 4'd15;
        repeat (3) @(posedge clk);
        #1;
        check_eq("b2b_busy_low", busy, 0);
        check_eq("b2b_done_low", done, 0);
        start = 1'b1; dividend = 4'd10; divisor = 4'd4;
        @(posedge clk); #1;
        start = 1'b0; dividend = 4'd1; divisor = 4'd1;
        check_eq("ign_done", done, 1);
        check_eq("ign_q", quotient, 4);
        check_eq("ign_r", remainder, 1);
        check_eq("b2b_busy", busy, 1);
        bcnt = 1;
        wait_done(lat, bcnt);
        check_eq("b2b_lat", lat, 5);
        check_eq("b2b_q", quotient, 2);
        check_eq("b2b_r", remainder, 2);

        // Reset during RUN aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_q", quotient, 0);
        check_eq("abort_r", remainder, 0);
        @(negedge clk); rst = 1'b0;
        bcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) bcnt++;
        end
        check_eq("abort_no_done", bcnt, 0);
        run_div("d10_4", 10, 4, 2, 2, 0, 5);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                eq = (b == 0) ? 15 : a / b;
                er = (b == 0) ? a : a % b;
                run_div($sformatf("sw%0d_%0d", a, b), a, b, eq, er, (b == 0) ? 1 : 0, (b == 0) ? 1 : 5);
                if (b != 0) begin
                    check_eq($sformatf("inv%0d_%0d", a, b),
                             mul_model(int'(quotient), b) + int'(remainder), a);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
